seg7_scan_mux: RTL and testbench

- Parametrised multi-digit seven-segment display scanner; successor to the fixed 3-anode segment driver on the CPU board.
- Takes a packed hex value plus per-digit decimal points and time-multiplexes it onto NUM_DIGITS common anodes.
- Adds a programmable refresh rate, an anti-ghosting blank gap and frame-coherent capture of the value.
- Sits between CPU result logic and board pins.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_mux.sv | 214 +++++++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types, constants and helpers for the seven-segment scanner.
// Segment patterns are gfedcba with seg[0] = a, active-low.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Packed table, element index = hex digit (F listed first, 0 last).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    // Width of a counter that runs 0..count-1; never narrower than one bit.
    function automatic int cnt_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan_mux.sv
// Multi-digit seven-segment scanner with refresh prescaler, blank gap and frame-coherent capture.
// Optional leading-zero blanking is compiled in with SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 3,
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int DW = cnt_width(NUM_DIGITS);
    localparam int PW = cnt_width(REFRESH_DIV);
    localparam int GW = cnt_width(GAP_CYCLES);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    state_e                  state_q, state_d;
    logic [DW-1:0]           digit_q, digit_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;

    logic                    reload;
    logic                    advance;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic [NUM_DIGITS-1:0]   cur_an;
    logic [6:0]              dec_seg;
    logic [6:0]              lit_seg;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0]   blank_q, blank_d, blank_load;
    logic                    zero_run;
    logic                    cur_blank;

    // A digit blanks when it and every more significant nibble are zero.
    always_comb begin
        zero_run   = 1'b1;
        blank_load = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (value[4*i +: 4] == 4'h0);
            blank_load[i] = zero_run & (i != 0);
        end
    end
`endif

    always_comb begin
        cur_nibble = '0;
        cur_dp     = 1'b0;
        cur_an     = '1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        cur_blank  = 1'b0;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_q == DW'(i)) begin
                cur_nibble = shadow_val_q[4*i +: 4];
                cur_dp     = shadow_dp_q[i];
                cur_an[i]  = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                cur_blank  = blank_q[i];
`endif
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble_i (cur_nibble),
        .seg_o    (dec_seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign lit_seg = cur_blank ? SEG_BLANK : dec_seg;
`else
    assign lit_seg = dec_seg;
`endif

    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        presc_d      = presc_q;
        gap_d        = gap_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        frame_done_d = 1'b0;
        reload       = 1'b0;
        advance      = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank_d      = blank_q;
`endif

        if (!enable) begin
            state_d = IDLE;
            digit_d = '0;
            presc_d = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    reload  = 1'b1;
                    digit_d = '0;
                    presc_d = '0;
                    state_d = SHOW;
                end
                SHOW: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        gap_d   = '0;
                        if (GAP_CYCLES == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        advance = 1'b1;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Shadows only change at a frame boundary, so a frame never tears.
            if (advance) begin
                state_d = SHOW;
                gap_d   = '0;
                if (digit_q == DIGIT_LAST) begin
                    digit_d      = '0;
                    reload       = 1'b1;
                    frame_done_d = 1'b1;
                end else begin
                    digit_d = digit_q + 1'b1;
                end
            end

            if (reload) begin
                shadow_val_d = value;
                shadow_dp_d  = dp_in;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                blank_d      = blank_load;
`endif
            end
        end
    end

    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (enable && state_q == SHOW) begin
            an_d  = cur_an;
            seg_d = lit_seg;
            dp_d  = ~cur_dp;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            digit_q      <= '0;
            presc_q      <= '0;
            gap_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            blank_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            presc_q      <= presc_d;
            gap_q        <= gap_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            blank_q      <= blank_d;
`endif
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench: three-digit scanner (REFRESH_DIV=4, GAP=1) plus a single-digit, gapless instance.
module tb_seg7_scan_mux;

    logic clk;
    logic rst_n;

    logic        en_a;
    logic [11:0] val_a;
    logic [2:0]  dpin_a;
    logic [2:0]  an_a;
    logic [6:0]  seg_a;
    logic        dp_a;
    logic        fd_a;

    logic        en_b;
    logic [3:0]  val_b;
    logic [0:0]  dpin_b;
    logic [0:0]  an_b;
    logic [6:0]  seg_b;
    logic        dp_b;
    logic        fd_b;

    int tests = 0;
    int fails = 0;

    logic [10:0] exp_q[$];
    logic [6:0]  hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan_mux #(.NUM_DIGITS(3), .REFRESH_DIV(4), .GAP_CYCLES(1)) dut_a (
        .clock      (clk),
        .reset_n    (rst_n),
        .enable     (en_a),
        .value      (val_a),
        .dp_in      (dpin_a),
        .an         (an_a),
        .seg        (seg_a),
        .dp         (dp_a),
        .frame_done (fd_a)
    );

    seg7_scan_mux #(.NUM_DIGITS(1), .REFRESH_DIV(4), .GAP_CYCLES(0)) dut_b (
        .clock      (clk),
        .reset_n    (rst_n),
        .enable     (en_b),
        .value      (val_b),
        .dp_in      (dpin_b),
        .an         (an_b),
        .seg        (seg_b),
        .dp         (dp_b),
        .frame_done (fd_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {an, seg, dp} for digit d of a three-digit frame.
    function automatic logic [10:0] exp_word(input logic [11:0] v, input logic [2:0] dps, input int d);
        logic [2:0] an_e;
        logic [6:0] s;
        logic       blank;
        an_e    = 3'b111;
        an_e[d] = 1'b0;
        s       = hex_tab[v[4*d +: 4]];
        blank   = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank   = (d != 0) && ((v >> (4*d)) == 12'h000);
`endif
        if (blank) s = 7'h7F;
        return {an_e, s, ~dps[d]};
    endfunction

    task automatic push_frame(input logic [11:0] v, input logic [2:0] dps, input int nlit);
        int cnt = 0;
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 4; k++) begin
                if (cnt < nlit) exp_q.push_back(exp_word(v, dps, d));
                cnt++;
            end
        end
    endtask

    task automatic wait_fd(input int n, input string name);
        int seen = 0;
        int budget = 0;
        while (seen < n && budget < 200) begin
            @(negedge clk);
            budget++;
            if (fd_a) seen++;
        end
        check(name, seen, n);
    endtask

    task automatic wait_an(input logic [2:0] target, input string name);
        int budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (an_a != target && budget < 100);
        check(name, an_a, target);
    endtask

    task automatic run_one(input logic [11:0] v, input logic [2:0] dps, input string name);
        val_a  = v;
        dpin_a = dps;
        push_frame(v, dps, 12);
        en_a = 1'b1;
        wait_fd(1, name);
        en_a = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_q_empty"}, exp_q.size(), 0);
    endtask

    // Monitor: every lit sample of dut_a is popped and compared; frame_done spacing is checked.
    int          cyc = 0;
    int          last_fd = 0;
    bit          fd_valid = 1'b0;
    int          fd_cnt_a = 0;
    logic [2:0]  prev_an = 3'b111;
    logic [10:0] w;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                fd_valid = 1'b0;
                prev_an  = 3'b111;
            end else begin
                if (an_a != 3'b111) begin
                    if (prev_an != 3'b111 && prev_an != an_a)
                        check("gap_between_digits", {prev_an, an_a}, {prev_an, 3'b111});
                    if (exp_q.size() == 0) begin
                        check("unexpected_lit", {an_a, seg_a, dp_a}, 11'h7FF);
                    end else begin
                        w = exp_q.pop_front();
                        check("lit_sample", {an_a, seg_a, dp_a}, w);
                    end
                end
                if (fd_a) begin
                    if (fd_valid) check("frame_period", cyc - last_fd, 15);
                    last_fd  = cyc;
                    fd_valid = 1'b1;
                    fd_cnt_a++;
                end
                if (!en_a) fd_valid = 1'b0;
                prev_an = an_a;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_fd;
        int last_b;
        int fdn_b;
        int budget;

        rst_n  = 1'b0;
        en_a   = 1'b0;
        val_a  = '0;
        dpin_a = '0;
        en_b   = 1'b0;
        val_b  = '0;
        dpin_b = '0;
        repeat (3) @(negedge clk);
        check("rst_an", an_a, 3'b111);
        check("rst_seg", seg_a, 7'h7F);
        check("rst_dp", dp_a, 1'b1);
        check("rst_fd", fd_a, 1'b0);

        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_dark", {an_a, seg_a, dp_a, fd_a}, 12'hFFE);
        end

        // Frame 1 shows 0A7; value changes mid-frame, frames 2 and 3 show 888; frame 3 aborted in digit 2.
        push_frame(12'h0A7, 3'b010, 12);
        push_frame(12'h888, 3'b010, 12);
        push_frame(12'h888, 3'b010, 9);
        val_a  = 12'h0A7;
        dpin_a = 3'b010;
        en_a   = 1'b1;
        wait_an(3'b101, "reach_digit1");
        val_a = 12'h888;
        wait_fd(2, "two_frames");
        wait_an(3'b011, "reach_digit2");
        en_a = 1'b0;
        n_fd = fd_cnt_a;
        @(negedge clk);
        check("abort_dark", {an_a, seg_a, dp_a}, 11'h7FF);
        repeat (15) @(negedge clk);
        check("abort_no_fd", fd_cnt_a, n_fd);
        check("abort_q_empty", exp_q.size(), 0);

        // Restart captures the fresh value from digit 0.
        val_a  = 12'h3C1;
        dpin_a = 3'b001;
        push_frame(12'h3C1, 3'b001, 12);
        push_frame(12'h3C1, 3'b001, 12);
        en_a = 1'b1;
        wait_fd(2, "restart_frames");
        en_a = 1'b0;
        repeat (3) @(negedge clk);
        check("restart_q_empty", exp_q.size(), 0);

        run_one(12'h005, 3'b000, "frame_005");
        run_one(12'h000, 3'b100, "frame_000");

        // Single digit, no gap: continuously lit, frame_done every 4 cycles.
        val_b  = 4'h9;
        dpin_b = 1'b1;
        en_b   = 1'b1;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (an_b != 1'b0 && budget < 10);
        check("b_lit_start", an_b, 1'b0);
        last_b = -1;
        fdn_b  = 0;
        for (int k = 0; k < 24; k++) begin
            check("b_lit", {an_b, seg_b, dp_b}, {1'b0, 7'b0010000, 1'b0});
            if (fd_b) begin
                if (last_b >= 0) check("b_period", k - last_b, 4);
                last_b = k;
                fdn_b++;
            end
            @(negedge clk);
        end
        check("b_fd_count", fdn_b, 6);

        #2 rst_n = 1'b0;
        #1 check("rst_mid_b", {an_b, seg_b, dp_b, fd_b}, {1'b1, 7'h7F, 1'b1, 1'b0});
        check("final_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
